// File: rtl/alu_flag_unit.sv
// NZCV flag unit for the execute stage: grouped zero detect, optional split
// pipeline stage, and the architectural flag register with stall/flush control.

module alu_flag_group_nor #(
   parameter int GROUP = 16
) (
   input  logic [GROUP-1:0] bits,
   output logic             groupZero
);
   assign groupZero = ~|bits;
endmodule

module alu_flag_unit #(
   parameter int WIDTH       = 64,
   parameter int GROUP       = 16,
   parameter int PIPE_STAGES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             set_flags,
   input  logic [WIDTH-1:0] result,
   input  logic             carry_in,
   input  logic             overflow_in,
   input  logic             stall,
   input  logic             flush,
   output logic             flag_n,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flags_written,
   output logic             flags_pending
);
   localparam int NGROUPS = WIDTH / GROUP;

   logic [NGROUPS-1:0] groupZero;
   logic               takeOp;
   logic               flagN, flagZ, flagC, flagV, flagsWritten;

   assign takeOp = in_valid & set_flags;

   // First reduction level: one NOR per GROUP-bit slice of the result.
   for (genvar g = 0; g < NGROUPS; g++) begin : gGroup
      alu_flag_group_nor #(.GROUP(GROUP)) uNor (
         .bits      (result[g*GROUP +: GROUP]),
         .groupZero (groupZero[g])
      );
   end

   if (PIPE_STAGES == 1) begin : gPipe
      typedef struct packed {
         logic [NGROUPS-1:0] gz;
         logic               n;
         logic               c;
         logic               v;
      } s1Payload_t;

      logic       s1Valid;
      s1Payload_t s1;

      // Capture and commit share the edge, so S1 refills while its old op retires.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            s1Valid      <= 1'b0;
            s1           <= '0;
            flagN        <= 1'b0;
            flagZ        <= 1'b0;
            flagC        <= 1'b0;
            flagV        <= 1'b0;
            flagsWritten <= 1'b0;
         end else if (flush) begin
            s1Valid      <= 1'b0;
            flagsWritten <= 1'b0;
         end else if (stall) begin
            flagsWritten <= 1'b0;
         end else begin
            s1Valid      <= takeOp;
            s1.gz        <= groupZero;
            s1.n         <= result[WIDTH-1];
            s1.c         <= carry_in;
            s1.v         <= overflow_in;
            flagsWritten <= s1Valid;
            if (s1Valid) begin
               flagN <= s1.n;
               flagZ <= &s1.gz;
               flagC <= s1.c;
               flagV <= s1.v;
            end
         end
      end

      assign flags_pending = s1Valid;
   end else begin : gComb
      // Full WIDTH-bit reduction feeds the flag register directly.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            flagN        <= 1'b0;
            flagZ        <= 1'b0;
            flagC        <= 1'b0;
            flagV        <= 1'b0;
            flagsWritten <= 1'b0;
         end else begin
            flagsWritten <= takeOp & ~stall & ~flush;
            if (takeOp && !stall && !flush) begin
               flagN <= result[WIDTH-1];
               flagZ <= &groupZero;
               flagC <= carry_in;
               flagV <= overflow_in;
            end
         end
      end

      assign flags_pending = 1'b0;
   end

   assign flag_n        = flagN;
   assign flag_z        = flagZ;
   assign flag_c        = flagC;
   assign flag_v        = flagV;
   assign flags_written = flagsWritten;
endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed bench: 64/16 pipelined unit, plus 64/16 and 32/8 combinational units.

module tb_alu_flag_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        inValid = 1'b0, setFlags = 1'b0, carryIn = 1'b0, overflowIn = 1'b0;
   logic        stall = 1'b0, flush = 1'b0;
   logic [63:0] res = '0;
   logic [31:0] res32;
   int          checks = 0, failures = 0;

   logic n1, z1, c1, v1, w1, p1;
   logic n0, z0, c0, v0, w0, p0;
   logic nS, zS, cS, vS, wS, pS;

   assign res32 = res[31:0];

   always #5 clk = ~clk;

   alu_flag_unit #(.WIDTH(64), .GROUP(16), .PIPE_STAGES(1)) u1 (
      .clk(clk), .reset(reset), .in_valid(inValid), .set_flags(setFlags), .result(res),
      .carry_in(carryIn), .overflow_in(overflowIn), .stall(stall), .flush(flush),
      .flag_n(n1), .flag_z(z1), .flag_c(c1), .flag_v(v1),
      .flags_written(w1), .flags_pending(p1));

   alu_flag_unit #(.WIDTH(64), .GROUP(16), .PIPE_STAGES(0)) u0 (
      .clk(clk), .reset(reset), .in_valid(inValid), .set_flags(setFlags), .result(res),
      .carry_in(carryIn), .overflow_in(overflowIn), .stall(stall), .flush(flush),
      .flag_n(n0), .flag_z(z0), .flag_c(c0), .flag_v(v0),
      .flags_written(w0), .flags_pending(p0));

   alu_flag_unit #(.WIDTH(32), .GROUP(8), .PIPE_STAGES(0)) u32 (
      .clk(clk), .reset(reset), .in_valid(inValid), .set_flags(setFlags), .result(res32),
      .carry_in(carryIn), .overflow_in(overflowIn), .stall(stall), .flush(flush),
      .flag_n(nS), .flag_z(zS), .flag_c(cS), .flag_v(vS),
      .flags_written(wS), .flags_pending(pS));

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic s, input logic [63:0] r,
                        input logic c, input logic o);
      inValid = v; setFlags = s; res = r; carryIn = c; overflowIn = o;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      tick; tick;
      chk("rst_n1", n1, 0); chk("rst_z1", z1, 0); chk("rst_c1", c1, 0); chk("rst_v1", v1, 0);
      chk("rst_w1", w1, 0); chk("rst_p1", p1, 0); chk("rst_z0", z0, 0); chk("rst_p0", p0, 0);
      reset = 1'b0;
      tick;

      // Zero detection, pipelined
      drive(1, 1, 64'h0, 0, 0); tick;
      chk("zd_pend", p1, 1); chk("zd_w_early", w1, 0); chk("zd_z_early", z1, 0);
      drive(1, 1, 64'h1, 0, 0); tick;
      chk("zd0_z", z1, 1); chk("zd0_n", n1, 0); chk("zd0_w", w1, 1);
      drive(1, 1, 64'h0001_0000_0000_0000, 0, 0); tick;
      chk("zd1_z", z1, 0);
      drive(1, 1, 64'h8000_0000_0000_0000, 0, 0); tick;
      chk("zdhi_z", z1, 0);
      drive(0, 0, 64'h0, 0, 0); tick;
      chk("zdmsb_z", z1, 0); chk("zdmsb_n", n1, 1); chk("zdmsb_w", w1, 1);
      tick;
      chk("zd_w_idle", w1, 0); chk("zd_p_idle", p1, 0);

      // Walking one, preceded by a zero so the first commit flips Z high
      drive(1, 1, 64'h0, 0, 0); tick;
      for (int i = 0; i < 64; i++) begin
         drive(1, 1, 64'd1 << i, 0, 0); tick;
         chk("walk1_z", z1, (i == 0));
         chk("walk1_n", n1, 1'b0);
      end
      drive(0, 0, 64'h0, 0, 0); tick;
      chk("walk1_last_z", z1, 0); chk("walk1_last_n", n1, 1);

      // Carry/overflow, then a non-setting op
      drive(1, 1, 64'h5, 1, 1); tick;
      drive(0, 0, 64'h0, 0, 0); tick;
      chk("cv_c", c1, 1); chk("cv_v", v1, 1); chk("cv_z", z1, 0); chk("cv_w", w1, 1);
      drive(1, 0, 64'h0, 0, 0); tick;
      chk("ns_pend", p1, 0); chk("ns_w0", w1, 0);
      drive(0, 0, 64'h0, 0, 0); tick;
      chk("ns_z", z1, 0); chk("ns_c", c1, 1); chk("ns_v", v1, 1); chk("ns_w1", w1, 0);

      // Back-to-back 0, 5, 0
      drive(1, 1, 64'h0, 0, 0); tick;
      drive(1, 1, 64'h5, 0, 0); tick;
      chk("b2b_z0", z1, 1); chk("b2b_w0", w1, 1);
      drive(1, 1, 64'h0, 0, 0); tick;
      chk("b2b_z1", z1, 0); chk("b2b_w1", w1, 1);
      drive(0, 0, 64'h0, 0, 0); tick;
      chk("b2b_z2", z1, 1); chk("b2b_w2", w1, 1);
      tick;
      chk("b2b_w3", w1, 0);

      // Stall with a pending zero result; held input 7 enters after release
      drive(1, 1, 64'h5, 0, 0); tick;
      drive(0, 0, 64'h0, 0, 0); tick;
      chk("st_pre_z", z1, 0);
      drive(1, 1, 64'h0, 0, 0); tick;
      chk("st_pend0", p1, 1);
      stall = 1'b1; drive(1, 1, 64'h7, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("st_z", z1, 0); chk("st_pend", p1, 1); chk("st_w", w1, 0);
      end
      stall = 1'b0; tick;
      chk("st_rel_z", z1, 1); chk("st_rel_w", w1, 1); chk("st_rel_p", p1, 1);
      drive(0, 0, 64'h0, 0, 0); tick;
      chk("st_next_z", z1, 0); chk("st_next_w", w1, 1);
      tick;
      chk("st_end_w", w1, 0); chk("st_end_p", p1, 0);

      // Flush a pending zero result; the same-cycle input is discarded
      drive(1, 1, 64'h0, 0, 0); tick;
      chk("fl_pend", p1, 1);
      flush = 1'b1; tick;
      chk("fl_p", p1, 0); chk("fl_z", z1, 0); chk("fl_w", w1, 0);
      flush = 1'b0; drive(0, 0, 64'h0, 0, 0); tick;
      chk("fl_after_z", z1, 0); chk("fl_after_w", w1, 0); chk("fl_after_p", p1, 0);

      // Flush and stall together: flush wins
      drive(1, 1, 64'h0, 0, 0); tick;
      chk("fs_pend", p1, 1);
      flush = 1'b1; stall = 1'b1; drive(0, 0, 64'h0, 0, 0); tick;
      chk("fs_p", p1, 0);
      flush = 1'b0; stall = 1'b0; tick;
      chk("fs_z", z1, 0); chk("fs_w", w1, 0);

      // Reset mid-cycle with an op in flight
      drive(1, 1, 64'h8000_0000_0000_0000, 1, 1); tick;
      drive(1, 1, 64'h0, 0, 0); tick;
      chk("rm_n", n1, 1); chk("rm_c", c1, 1); chk("rm_pend", p1, 1);
      drive(0, 0, 64'h0, 0, 0);
      #2 reset = 1'b1;
      #1;
      chk("rm_async_n", n1, 0); chk("rm_async_c", c1, 0); chk("rm_async_v", v1, 0);
      chk("rm_async_w", w1, 0); chk("rm_async_p", p1, 0);
      #1 reset = 1'b0;
      tick; tick;
      chk("rm_lost_z", z1, 0); chk("rm_lost_w", w1, 0); chk("rm_lost_p", p1, 0);

      // Combinational variants: 64/16 and 32/8, one-edge latency
      drive(1, 1, 64'h0, 0, 0); tick;
      chk("c_z0_64", z0, 1); chk("c_w0_64", w0, 1); chk("c_p0_64", p0, 0);
      chk("c_z0_32", zS, 1); chk("c_p0_32", pS, 0);
      drive(1, 1, 64'h1, 0, 0); tick;
      chk("c_z1_64", z0, 0); chk("c_z1_32", zS, 0);
      drive(1, 1, 64'h0001_0000_0000_0000, 0, 0); tick;
      chk("c_zhi_64", z0, 0); chk("c_zhi_32", zS, 1);
      drive(1, 1, 64'h8000_0000_0000_0000, 0, 0); tick;
      chk("c_msb_z64", z0, 0); chk("c_msb_n64", n0, 1);
      chk("c_msb_z32", zS, 1); chk("c_msb_n32", nS, 0);
      drive(1, 1, 64'h0000_0000_8000_0000, 1, 0); tick;
      chk("c_b31_n64", n0, 0); chk("c_b31_n32", nS, 1);
      chk("c_b31_z32", zS, 0); chk("c_b31_c32", cS, 1); chk("c_b31_v32", vS, 0);
      for (int i = 0; i < 64; i++) begin
         drive(1, 1, 64'd1 << i, 0, 0); tick;
         chk("c_walk_z64", z0, 0); chk("c_walk_n64", n0, (i == 63));
         chk("c_walk_z32", zS, (i >= 32)); chk("c_walk_n32", nS, (i == 31));
      end
      drive(1, 1, 64'h0, 0, 0); tick;
      chk("c_b2b_z0", z0, 1); chk("c_b2b_w0", w0, 1); chk("c_b2b_s0", zS, 1);
      drive(1, 1, 64'h5, 0, 0); tick;
      chk("c_b2b_z1", z0, 0); chk("c_b2b_w1", w0, 1); chk("c_b2b_s1", zS, 0);
      drive(1, 1, 64'h0, 0, 0); tick;
      chk("c_b2b_z2", z0, 1); chk("c_b2b_w2", w0, 1); chk("c_b2b_s2", wS, 1);
      drive(0, 0, 64'h0, 0, 0); tick;
      chk("c_b2b_w3", w0, 0); chk("c_b2b_p", p0, 0);
      drive(1, 1, 64'h5, 0, 0); flush = 1'b1; tick;
      chk("c_fl_z", z0, 1); chk("c_fl_w", w0, 0);
      flush = 1'b0; stall = 1'b1; tick;
      chk("c_st_z", z0, 1); chk("c_st_w", wS, 0);
      stall = 1'b0; drive(1, 0, 64'h5, 0, 0); tick;
      chk("c_ns_z", z0, 1); chk("c_ns_w", w0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_flag_unit.md
# alu_flag_unit

Parametrised, registered NZCV flag unit for the execute stage of the pipelined CPU. It takes the ALU result plus the ALU's carry and overflow outputs and detects zero with a two-level grouped NOR/AND reduction. It holds the architectural flag register, written only by flag-setting instructions. An optional internal pipeline stage splits the zero reduction, and stall/flush controls let the hazard unit hold or squash an in-flight flag update. It sits between the ALU and the branch-condition logic; `flags_pending` feeds the hazard unit for B.cond interlocks.

## Interface
- `WIDTH`, default 64: result width in bits; must be a multiple of `GROUP`.
- `GROUP`, default 16: bits per first-level NOR group; must be ≥ 2. NGROUPS = WIDTH/GROUP.
- `PIPE_STAGES`, default 1: 0 means the zero reduction is fully combinational into the flag register; 1 means group-NOR outputs are registered before the final AND. Other values are illegal.

Ports:
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: an ALU result is present this cycle.
- `set_flags` input, 1 bit: the instruction writes flags. It is ignored unless `in_valid` is high.
- `result` input, `WIDTH` bits: ALU result.
- `carry_in` input, 1 bit: ALU carry out.
- `overflow_in` input, 1 bit: ALU signed overflow.
- `stall` input, 1 bit: hold all internal state and block the commit.
- `flush` input, 1 bit: squash the uncommitted in-flight update.
- `flag_n`, `flag_z`, `flag_c`, `flag_v` output, 1 bit each: architectural flags, registered.
- `flags_written` output, 1 bit: one-cycle pulse on the cycle after a commit edge.
- `flags_pending` output, 1 bit: a flag-setting op is captured but not yet committed. This output is always 0 when PIPE_STAGES=0.

## Operation
- Group zero: gz[g] = NOR of result[g·GROUP +: GROUP], one bit per group.
- Zero: Z = AND of all gz. N = result[WIDTH-1]. C = `carry_in`. V = `overflow_in`.
- **PIPE_STAGES=1**, stage register S1 holds {s1_valid, gz[NGROUPS-1:0], N, C, V}:
  - Capture: if !stall and !flush, then s1_valid ← in_valid & set_flags and the payload ← the current inputs.
  - An op with `set_flags`=0 loads s1_valid=0.
  - Commit: if s1_valid and !stall and !flush, then flags ← {N, AND(s1 gz), C, V} and `flags_written` is set to 1 for one cycle.
  - `flags_pending` = s1_valid, combinational from the register.
- **PIPE_STAGES=0**: commit happens directly when in_valid & set_flags & !stall & !flush. There is no S1.
- Stall: S1, the flags and the payload all hold. `flags_written` drops to 0 on the next edge. The upstream stage keeps `in_valid`/`result` stable. An input presented during a stall is not captured.
- Flush: on the next edge s1_valid ← 0 and no commit occurs. The committed flags are unchanged. An input presented in the same cycle as `flush` is discarded. Flush has priority over stall.
- A capture and a commit on the same edge are both performed: S1 is refilled while its old contents commit. Back-to-back flag-setting ops therefore commit one per cycle with no bubbles.
- A non-flag-setting op never alters the flags.
- Reset mid-operation: the in-flight op is lost, no commit occurs, and all state returns to its reset values immediately (asynchronously).

## Timing
- Reset values:
  - `flag_n`=`flag_z`=`flag_c`=`flag_v`=0.
  - `flags_written`=0.
  - `flags_pending`=0.
  - s1_valid=0, and the S1 payload is 0.
- Latency from an input cycle to the flags being visible: PIPE_STAGES+1 rising edges. With PIPE_STAGES=1, an input at edge k is captured at k and committed at k+1, so the flags are valid after edge k+1.
- Throughput: 1 op per cycle when unstalled.
- `flags_written` is high for exactly the cycle following each commit edge.
- Critical path:
  - PIPE_STAGES=1 splits it into a GROUP-input NOR on one side and an NGROUPS-input AND on the other.
  - PIPE_STAGES=0 has a single WIDTH-bit reduction.

## Test plan
1. **Reset:** assert `reset` mid-cycle with s1_valid=1 → all outputs are 0 immediately. After deassert, no commit ever appears for the lost op.
2. **Zero detection** (WIDTH=64, GROUP=16, PIPE=1): send `result`=0 with set_flags=1, then 64'h1, then 64'h0001_0000_0000_0000, then 64'h8000_0000_0000_0000.
   - Flags after each commit: Z=1,N=0; Z=0; Z=0; then Z=0,N=1.
   - A single 1 walked through every bit position always gives Z=0.
3. **Carry/overflow and non-setting ops:** send carry_in=1, overflow_in=1 with set_flags=1 → C=V=1 two edges later. Then send set_flags=0 with result=0 → flags remain Z=0, C=V=1, and `flags_written` stays 0.
4. **Back-to-back:** three consecutive set_flags ops with results 0, 5, 0 → Z follows 1, 0, 1 on consecutive cycles, and `flags_written` stays high for 3 cycles.
5. **Stall:** hold `stall`=1 for 3 cycles with s1_valid=1 (pending result 0) → the flags are unchanged and `flags_pending`=1 throughout. The commit occurs on the first edge after stall drops.
6. **Flush:**
   - Flush with a pending result=0 → no commit, Z keeps its old value 0, and `flags_pending` drops after the edge.
   - Flush and stall together → the flush wins.
   - Repeat cases 2 and 4 with PIPE_STAGES=0 and with WIDTH=32, GROUP=8 → latency is 1 edge and `flags_pending` stays 0.
